// File: rtl/keccak_pkg.sv
// keccak_pkg: mode encoding, padding constants, FSM state type and the
// rate / domain-byte lookups shared by the Keccak padders.
package keccak_pkg;

  localparam logic [1:0] MODE_SHA3_256 = 2'd0;
  localparam logic [1:0] MODE_SHA3_512 = 2'd1;
  localparam logic [1:0] MODE_SHAKE128 = 2'd2;
  localparam logic [1:0] MODE_SHAKE256 = 2'd3;

  localparam logic [7:0] PAD_FINAL = 8'h80;
  localparam logic [7:0] DOM_SHA3  = 8'h06;
  localparam logic [7:0] DOM_SHAKE = 8'h1F;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_FILL   = 2'd1,
    ST_EMIT   = 2'd2
  } pad_state_e;

  // Rate in bits for each mode.
  function automatic int unsigned rate_bits(input logic [1:0] mode);
    case (mode)
      MODE_SHA3_512: return 576;
      MODE_SHAKE128: return 1344;
      default:       return 1088;
    endcase
  endfunction

  function automatic logic [7:0] dom_byte(input logic [1:0] mode);
    return ((mode == MODE_SHAKE128) || (mode == MODE_SHAKE256)) ? DOM_SHAKE : DOM_SHA3;
  endfunction

endpackage

// File: rtl/keccak_pad_word.sv
// keccak_pad_word: keeps the first nbytes bytes of a word, places the domain
// byte right after them and zeroes the rest; nbytes == IN_W/8 passes the word through.
module keccak_pad_word #(
  parameter int unsigned IN_W = 64
) (
  input  logic [IN_W-1:0]         word_i,
  input  logic [$clog2(IN_W/8):0] nbytes_i,
  input  logic [7:0]              dom_i,
  output logic [IN_W-1:0]         padded_c_o
);

  localparam int unsigned BPW  = IN_W / 8;
  localparam int unsigned NB_W = $clog2(BPW) + 1;

  always_comb begin
    padded_c_o = '0;
    for (int unsigned b = 0; b < BPW; b++) begin
      if (NB_W'(b) < nbytes_i) begin
        padded_c_o[IN_W-1-8*b -: 8] = word_i[IN_W-1-8*b -: 8];
      end else if (NB_W'(b) == nbytes_i) begin
        padded_c_o[IN_W-1-8*b -: 8] = dom_i;
      end
    end
  end

endmodule

// File: rtl/keccak_padder_multi.sv
// keccak_padder_multi: packs IN_W-bit words into one rate block and applies pad10*1
// for SHA3-256/512 and SHAKE128/256. Define KECCAK_PADDER_ERR_EN for the sticky err output.
module keccak_padder_multi
  import keccak_pkg::*;
#(
  parameter int unsigned IN_W     = 64,
  parameter int unsigned MAX_RATE = 1344
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic [IN_W-1:0]         in_data,
  input  logic [$clog2(IN_W/8):0] in_bytes,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [MAX_RATE-1:0]     out_block,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef KECCAK_PADDER_ERR_EN
  ,
  output logic                    err
`endif
);

  localparam int unsigned BPW       = IN_W / 8;
  localparam int unsigned NB_W      = $clog2(BPW) + 1;
  localparam int unsigned MAX_WORDS = MAX_RATE / IN_W;
  localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1);

  pad_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MAX_RATE-1:0] buf_q, buf_d;
  logic [1:0]          mode_q, mode_d;
  logic                active_q, active_d;
  logic                pad_pend_q, pad_pend_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;

  logic [1:0]          mode_sel;
  logic [CNT_W-1:0]    rate_words;
  logic [7:0]          dom;
  logic [NB_W-1:0]     nbytes;
  logic                in_full;
  logic                last_slot;
  logic                accept;
  logic [IN_W-1:0]     pw_word;
  logic [NB_W-1:0]     pw_nbytes;
  logic [7:0]          pw_dom;
  logic [IN_W-1:0]     pw_out;
  logic                wr_en;
  logic                pad_fin;
  logic [IN_W-1:0]     wr_word;

  // The live mode applies only to the first word; afterwards the latched one rules.
  assign mode_sel   = active_q ? mode_q : mode;
  assign rate_words = CNT_W'(rate_bits(mode_sel) / IN_W);
  assign dom        = dom_byte(mode_sel);
  assign nbytes     = (in_bytes > NB_W'(BPW)) ? NB_W'(BPW) : in_bytes;
  assign in_full    = (nbytes == NB_W'(BPW));
  assign last_slot  = ((cnt_q + CNT_W'(1)) == rate_words);
  assign accept     = (state_q == ST_ACCEPT) && in_valid && in_ready_q;

  // Word padder input mux: message words in ACCEPT, domain/zero words in FILL.
  always_comb begin
    pw_word   = '0;
    pw_nbytes = '0;
    pw_dom    = 8'h00;
    if (state_q == ST_ACCEPT) begin
      pw_word   = in_data;
      pw_nbytes = in_last ? nbytes : NB_W'(BPW);
      pw_dom    = dom;
    end else if (pad_pend_q) begin
      pw_dom = dom;
    end
  end

  keccak_pad_word #(.IN_W(IN_W)) u_pad_word (
    .word_i     (pw_word),
    .nbytes_i   (pw_nbytes),
    .dom_i      (pw_dom),
    .padded_c_o (pw_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_ACCEPT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    mode_d     = mode_q;
    active_d   = active_q;
    pad_pend_d = pad_pend_q;
    out_last_d = out_last_q;
    wr_en      = 1'b0;
    pad_fin    = 1'b0;

    unique case (state_q)
      ST_ACCEPT: begin
        if (accept) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (!active_q) begin
            mode_d   = mode;
            active_d = 1'b1;
          end
          if (in_last && in_full) pad_pend_d = 1'b1;
          if (last_slot) begin
            // A short final word in the last slot closes the block right here.
            state_d    = ST_EMIT;
            pad_fin    = in_last && !in_full;
            out_last_d = in_last && !in_full;
          end else if (in_last) begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        wr_en      = 1'b1;
        cnt_d      = cnt_q + CNT_W'(1);
        pad_pend_d = 1'b0;
        if (last_slot) begin
          state_d    = ST_EMIT;
          pad_fin    = 1'b1;
          out_last_d = 1'b1;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          cnt_d      = '0;
          buf_d      = '0;
          out_last_d = 1'b0;
          if (pad_pend_q) begin
            state_d = ST_FILL;
          end else begin
            state_d = ST_ACCEPT;
            if (out_last_q) active_d = 1'b0;
          end
        end
      end
      default: state_d = ST_ACCEPT;
    endcase

    wr_word = pw_out;
    if (pad_fin) wr_word[7:0] = wr_word[7:0] | PAD_FINAL;

    for (int unsigned i = 0; i < MAX_WORDS; i++) begin
      if (wr_en && (cnt_q == CNT_W'(i))) buf_d[MAX_RATE-1-i*IN_W -: IN_W] = wr_word;
    end
  end

  assign in_ready_d  = (state_d == ST_ACCEPT);
  assign out_valid_d = (state_d == ST_EMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      buf_q       <= '0;
      mode_q      <= '0;
      active_q    <= 1'b0;
      pad_pend_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      mode_q      <= mode_d;
      active_q    <= active_d;
      pad_pend_q  <= pad_pend_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_block = buf_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

`ifdef KECCAK_PADDER_ERR_EN
  logic err_q, err_d;

  // Sticky: oversized final byte count, or mode wobbling mid-message.
  assign err_d = err_q
               | (in_valid & in_last & (in_bytes > NB_W'(BPW)))
               | (active_q & (mode != mode_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule
